// File: rtl/fp16_add_engine_if.sv
// Host-side byte port of the fp16 add engine: memory access bus plus the done flag.
interface fp16_add_engine_if;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       done;

  modport master (output host_we, host_addr, host_wdata, input host_rdata, done);
  modport slave  (input host_we, host_addr, host_wdata, output host_rdata, done);
endinterface

// File: rtl/fp16_add_engine.sv
// Standalone fp16 adder: fetches two big-endian operands from a private 256x8 memory,
// adds them with truncation and saturation, writes the result back and raises done.
module fp16_add_engine #(
  parameter logic [7:0] OPA_ADDR = 8'd128,
  parameter logic [7:0] OPB_ADDR = 8'd130,
  parameter logic [7:0] RES_ADDR = 8'd132
) (
  input  logic               clk,
  input  logic               reset,
  fp16_add_engine_if.slave   host
);

  localparam logic [7:0] OPA_LO = 8'(OPA_ADDR + 8'd1);
  localparam logic [7:0] OPB_LO = 8'(OPB_ADDR + 8'd1);
  localparam logic [7:0] RES_LO = 8'(RES_ADDR + 8'd1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_UNPACK, S_ALIGN,
    S_ADDSUB, S_NORM, S_PACK, S_WR0, S_WR1, S_DONE
  } state_e;

  logic [7:0]  mem [256];

  state_e      state_q;
  logic        done_q;
  logic [15:0] a_q, b_q, res_q;
  logic        sx_q, sy_q;
  logic [5:0]  ex_q;
  logic [4:0]  ey_q;
  logic [10:0] sigx_q, sigy_q;
  logic [11:0] sum_q;

  logic [4:0]  ea_d, eb_d, shamt_d;
  logic [10:0] siga_d, sigb_d, sigy_al_d;
  logic        a_ge_b_d;
  logic [11:0] sum_d;

  // Result encoding: exact zero is unsigned, exponent overflow clamps to the largest magnitude.
  function automatic logic [15:0] pack_result(input logic s, input logic [5:0] e,
                                              input logic zero, input logic [9:0] frac);
    if (zero)            return 16'h0000;
    else if (e > 6'd31)  return {s, 15'h7FFF};
    else                 return {s, e[4:0], frac};
  endfunction

  always_comb begin
    ea_d     = a_q[14:10];
    eb_d     = b_q[14:10];
    siga_d   = {|ea_d, a_q[9:0]};
    sigb_d   = {|eb_d, b_q[9:0]};
    a_ge_b_d = {ea_d, siga_d} >= {eb_d, sigb_d};
    shamt_d  = ex_q[4:0] - ey_q;
    sigy_al_d = (shamt_d >= 5'd11) ? 11'd0 : (sigy_q >> shamt_d);
    if (sx_q == sy_q) sum_d = {1'b0, sigx_q} + {1'b0, sigy_q};
    else              sum_d = {1'b0, sigx_q} - {1'b0, sigy_q};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      ex_q    <= '0;
      ey_q    <= '0;
      sigx_q  <= '0;
      sigy_q  <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_RD0;
        S_RD0: begin a_q[15:8] <= mem[OPA_ADDR]; state_q <= S_RD1; end
        S_RD1: begin a_q[7:0]  <= mem[OPA_LO];   state_q <= S_RD2; end
        S_RD2: begin b_q[15:8] <= mem[OPB_ADDR]; state_q <= S_RD3; end
        S_RD3: begin b_q[7:0]  <= mem[OPB_LO];   state_q <= S_UNPACK; end
        // Larger magnitude becomes X so a subtraction never goes negative.
        S_UNPACK: begin
          if (a_ge_b_d) begin
            sx_q <= a_q[15]; ex_q <= {1'b0, ea_d}; sigx_q <= siga_d;
            sy_q <= b_q[15]; ey_q <= eb_d;         sigy_q <= sigb_d;
          end else begin
            sx_q <= b_q[15]; ex_q <= {1'b0, eb_d}; sigx_q <= sigb_d;
            sy_q <= a_q[15]; ey_q <= ea_d;         sigy_q <= siga_d;
          end
          state_q <= S_ALIGN;
        end
        S_ALIGN: begin sigy_q <= sigy_al_d; state_q <= S_ADDSUB; end
        S_ADDSUB: begin sum_q <= sum_d; state_q <= S_NORM; end
        // One left shift per cycle; a zero sum skips the loop to keep latency bounded.
        S_NORM: begin
          if (sum_q[11]) begin
            sum_q   <= sum_q >> 1;
            ex_q    <= ex_q + 6'd1;
            state_q <= S_PACK;
          end else if (sum_q != 12'd0 && !sum_q[10] && ex_q != 6'd0) begin
            sum_q <= sum_q << 1;
            ex_q  <= ex_q - 6'd1;
          end else begin
            state_q <= S_PACK;
          end
        end
        S_PACK: begin
          res_q   <= pack_result(sx_q, ex_q, sum_q == 12'd0, sum_q[9:0]);
          state_q <= S_WR0;
        end
        S_WR0: state_q <= S_WR1;
        S_WR1: begin state_q <= S_DONE; done_q <= 1'b1; end
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory is never cleared; host owns it during reset, the engine only while running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (host.host_we) mem[host.host_addr] <= host.host_wdata;
    end else if (state_q == S_WR0) begin
      mem[RES_ADDR] <= res_q[15:8];
    end else if (state_q == S_WR1) begin
      mem[RES_LO] <= res_q[7:0];
    end
  end

  assign host.host_rdata = mem[host.host_addr];
  assign host.done       = done_q;

endmodule

// File: tb/tb_fp16_add_engine.sv
// Directed and random-tolerance bench for fp16_add_engine through its host byte port.
module tb_fp16_add_engine;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  fp16_add_engine_if bus();

  fp16_add_engine dut (.clk(clk), .reset(reset), .host(bus));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves us at the following negedge.
  task automatic wr_byte(input logic [7:0] addr, input logic [7:0] data);
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    @(negedge clk);
    bus.host_we    = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] addr, output logic [7:0] data);
    bus.host_addr = addr;
    #1;
    data = bus.host_rdata;
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    wr_byte(8'd128, a[15:8]);
    wr_byte(8'd129, a[7:0]);
    wr_byte(8'd130, b[15:8]);
    wr_byte(8'd131, b[7:0]);
  endtask

  // Loads operands in reset, runs to done, reads the result back, then re-enters reset.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res);
    int cycles;
    logic [7:0] hi, lo, chk;
    load_ops(a, b);
    reset = 1'b1;
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_eq({tag, "_lat"}, 32'(cycles <= 24), 32'd1);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    rd_byte(8'd132, hi);
    rd_byte(8'd133, lo);
    res = {hi, lo};
    // Host write while running must be ignored, and done must hold.
    wr_byte(8'd128, ~a[15:8]);
    rd_byte(8'd128, chk);
    check_eq({tag, "_wr_ign"}, 32'(chk), 32'(a[15:8]));
    check_eq({tag, "_done_hold"}, 32'(bus.done), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_eq({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
    logic [15:0] res;
    run_op(tag, a, b, res);
    check_eq(tag, 32'(res), 32'(exp));
  endtask

  function automatic real fp_val(input logic [15:0] v);
    real r;
    int  e;
    r = real'({|v[14:10], v[9:0]});
    e = int'(v[14:10]) - 25;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return v[15] ? -r : r;
  endfunction

  initial begin
    logic [15:0] a, b, res;
    logic [7:0]  hi, lo;
    real         exact, got, diff;
    reset = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = 8'd0;
    bus.host_wdata = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_done", 32'(bus.done), 32'd0);

    directed("add_small", 16'h1A04, 16'h1A04, 16'h1E04);
    directed("add_mid",   16'h4204, 16'h4204, 16'h4604);
    directed("align2",    16'h4A10, 16'h4204, 16'h4B91);
    directed("cancel",    16'h3C00, 16'hBC00, 16'h0000);
    directed("sub_norm",  16'h4000, 16'hBC00, 16'h3C00);
    directed("sub_neg",   16'h3C00, 16'hC000, 16'hBC00);
    directed("saturate",  16'h7FFF, 16'h7FFF, 16'h7FFF);
    directed("shift_out", 16'h5000, 16'h0001, 16'h5000);

    // Abort mid-run: sentinel result bytes must survive a long reset.
    wr_byte(8'd132, 8'hAA);
    wr_byte(8'd133, 8'h55);
    load_ops(16'h4A10, 16'h4204);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    repeat (25) @(negedge clk);
    check_eq("abort_done_hold", 32'(bus.done), 32'd0);
    rd_byte(8'd132, hi);
    rd_byte(8'd133, lo);
    check_eq("abort_res", 32'({hi, lo}), 32'h AA55);
    wr_byte(8'd130, 8'hC0);
    rd_byte(8'd130, hi);
    check_eq("rst_wr_lands", 32'(hi), 32'hC0);
    directed("rerun", 16'h3C00, 16'hC000, 16'hBC00);

    for (int i = 0; i < 25; i++) begin
      a = {1'b0, 5'($urandom_range(2, 28)), 10'($urandom_range(0, 1023))};
      b = {1'b0, 5'($urandom_range(2, 28)), 10'($urandom_range(0, 1023))};
      run_op("rnd", a, b, res);
      exact = fp_val(a) + fp_val(b);
      got   = fp_val(res);
      diff  = (got > exact) ? got - exact : exact - got;
      if (diff > 0.01 * exact)
        $display("rnd detail a=%h b=%h res=%h", a, b, res);
      check_eq("rnd_tol", 32'(diff <= 0.01 * exact), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
